// File: rtl/sram_seq_reader_pkg.sv
// Shared widths for the sequence SRAM read path and a small sizing helper.
package sram_seq_reader_pkg;

  localparam int SRAM_WORD_BIT = 128;
  localparam int SRAM_ADDR_BIT = 11;
  localparam int BASE_BIT_W    = 2;
  localparam int SEQ_LEN_BIT   = 16;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/sram_seq_reader_if.sv
// Start request, SRAM read port, base stream and status of the sequence reader.
interface sram_seq_reader_if
  import sram_seq_reader_pkg::*;
#(
  parameter int WORD_WIDTH = SRAM_WORD_BIT,
  parameter int ADDR_WIDTH = SRAM_ADDR_BIT,
  parameter int BASE_BIT   = BASE_BIT_W,
  parameter int LEN_WIDTH  = SEQ_LEN_BIT
);
  logic                  start_valid;
  logic                  start_ready;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [LEN_WIDTH-1:0]  start_len;
  logic                  sram_cen;
  logic                  sram_wen;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [WORD_WIDTH-1:0] sram_q;
  logic                  base_valid;
  logic                  base_ready;
  logic [BASE_BIT-1:0]   base_data;
  logic                  base_last;
  logic                  busy;
  logic                  done;

  modport master (
    input  start_valid, start_addr, start_len, sram_q, base_ready,
    output start_ready, sram_cen, sram_wen, sram_addr,
           base_valid, base_data, base_last, busy, done
  );

  modport slave (
    output start_valid, start_addr, start_len, sram_q, base_ready,
    input  start_ready, sram_cen, sram_wen, sram_addr,
           base_valid, base_data, base_last, busy, done
  );
endinterface

// File: rtl/sram_seq_reader_seq_word_buffer.sv
// Two-word prefetch FIFO; the head word shifts out one base per pop, push and free may coincide.
// Latency: a pushed word is presentable the cycle after the push; caller must never push into a full buffer.
module sram_seq_reader_seq_word_buffer #(
  parameter int WORD_WIDTH = 128,
  parameter int BASE_BIT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [WORD_WIDTH-1:0] push_dat_i,
  input  logic                  pop_i,
  input  logic                  last_i,
  output logic                  head_vld_o,
  output logic [BASE_BIT-1:0]   head_base_o,
  output logic [1:0]            cnt_o,
  output logic                  free_o
);
  localparam int BPW   = WORD_WIDTH / BASE_BIT;
  localparam int IDX_W = $clog2(BPW);

  logic [WORD_WIDTH-1:0] head_q, head_d;
  logic [WORD_WIDTH-1:0] next_q, next_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  vld_q;
  logic                  free;

  assign free = pop_i && ((idx_q == IDX_W'(BPW - 1)) || last_i);

  always_comb begin
    head_d = head_q;
    next_d = next_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    if (free) begin
      idx_d = '0;
      if (cnt_q == 2'd2) begin
        head_d = next_q;
        if (push_i) next_d = push_dat_i;
        else        cnt_d  = 2'd1;
      end else begin
        // Single resident word retires; an arriving word takes the head directly.
        if (push_i) head_d = push_dat_i;
        else        cnt_d  = 2'd0;
      end
    end else begin
      if (pop_i) begin
        head_d = head_q >> BASE_BIT;
        idx_d  = idx_q + IDX_W'(1);
      end
      if (push_i) begin
        if (cnt_q == 2'd0) head_d = push_dat_i;
        else               next_d = push_dat_i;
        cnt_d = cnt_q + 2'd1;
      end
    end
    if (flush_i) begin
      head_d = '0;
      next_d = '0;
      cnt_d  = 2'd0;
      idx_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      next_q <= '0;
      cnt_q  <= 2'd0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      next_q <= next_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      vld_q  <= (cnt_d != 2'd0);
    end
  end

  assign head_vld_o  = vld_q;
  assign head_base_o = head_q[BASE_BIT-1:0];
  assign cnt_o       = cnt_q;
  assign free_o      = free;
endmodule

// File: rtl/sram_seq_reader.sv
// Streams len 2-bit bases from sequence SRAM starting at a word address, LSB base first.
// Latency: first base 3 cycles after start, then 1 base/cycle; base_ready low holds the base and stops prefetch at 2 words.
module sram_seq_reader
  import sram_seq_reader_pkg::*;
#(
  parameter int WORD_WIDTH = SRAM_WORD_BIT,
  parameter int ADDR_WIDTH = SRAM_ADDR_BIT,
  parameter int BASE_BIT   = BASE_BIT_W,
  parameter int LEN_WIDTH  = SEQ_LEN_BIT
) (
  input logic               clk,
  input logic               rst,
  sram_seq_reader_if.master bus
);
  localparam int BPW    = WORD_WIDTH / BASE_BIT;
  localparam int IDX_W  = $clog2(BPW);
  localparam int WCNT_W = LEN_WIDTH - IDX_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  cen_q, cen_d;
  logic [WCNT_W-1:0]     words_q, words_d;
  logic [LEN_WIDTH-1:0]  bases_q, bases_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  last_q, last_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  buf_vld;
  logic [BASE_BIT-1:0]   buf_base;
  logic [1:0]            buf_cnt;
  logic                  buf_free;
  logic                  accept;
  logic                  final_base;
  logic [2:0]            cnt_next;
  logic [2:0]            committed;

  assign accept     = buf_vld && bus.base_ready;
  assign final_base = (bases_q == LEN_WIDTH'(1));
  assign cnt_next   = {1'b0, buf_cnt} + {2'b0, rd_vld_q} - {2'b0, buf_free};
  // Slots spoken for after this edge: resident words plus the read on the bus now.
  assign committed  = cnt_next + {2'b0, ~cen_q};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cen_d    = 1'b1;
    words_d  = words_q;
    bases_d  = bases_q;
    rd_vld_d = ~cen_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_valid) begin
          bases_d = bus.start_len;
          if (bus.start_len == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_STREAM;
            cen_d   = 1'b0;
            addr_d  = bus.start_addr;
            words_d = WCNT_W'(ceil_div(int'(bus.start_len), BPW)) - WCNT_W'(1);
          end
        end
      end
      ST_STREAM: begin
        if (accept) begin
          bases_d = bases_q - LEN_WIDTH'(1);
          if (final_base) state_d = ST_DONE;
        end
        if (state_d == ST_STREAM && words_q != '0 && committed < 3'd2) begin
          cen_d   = 1'b0;
          addr_d  = addr_q + ADDR_WIDTH'(1);
          words_d = words_q - WCNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    last_d  = (state_d == ST_STREAM) && (bases_d == LEN_WIDTH'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      cen_q    <= 1'b1;
      words_q  <= '0;
      bases_q  <= '0;
      rd_vld_q <= 1'b0;
      last_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cen_q    <= cen_d;
      words_q  <= words_d;
      bases_q  <= bases_d;
      rd_vld_q <= rd_vld_d;
      last_q   <= last_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  sram_seq_reader_seq_word_buffer #(
    .WORD_WIDTH (WORD_WIDTH),
    .BASE_BIT   (BASE_BIT)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (accept && final_base),
    .push_i      (rd_vld_q),
    .push_dat_i  (bus.sram_q),
    .pop_i       (accept),
    .last_i      (final_base),
    .head_vld_o  (buf_vld),
    .head_base_o (buf_base),
    .cnt_o       (buf_cnt),
    .free_o      (buf_free)
  );

  assign bus.start_ready = ready_q;
  assign bus.sram_cen    = cen_q;
  assign bus.sram_wen    = 1'b1;
  assign bus.sram_addr   = addr_q;
  assign bus.base_valid  = buf_vld;
  assign bus.base_data   = buf_base;
  assign bus.base_last   = last_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: doc/sram_seq_reader.md
# sram_seq_reader

Streams a packed base sequence out of single-port sequence SRAM to the PE array. Given a start address and a length in bases, it drives the SRAM read port, absorbs the one-cycle read latency in a two-word prefetch buffer, and emits one 2-bit base per cycle over a valid/ready handshake. It is the read-side master of the 128-bit × 2048-word sequence SRAM and the feeder of the PE array's query/reference input.

## Interface
Parameters:
- WORD_WIDTH, 128, SRAM word width; must be a multiple of BASE_BIT.
- ADDR_WIDTH, 11, SRAM address width.
- BASE_BIT, 2, bits per base.
- LEN_WIDTH, 16, width of the length field, counted in bases.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_valid  in  1  request to stream a sequence.
- start_ready  out  1  high only in IDLE.
- start_addr  in  ADDR_WIDTH  first word address.
- start_len  in  LEN_WIDTH  number of bases; 0 is legal.
- sram_cen  out  1  SRAM chip enable, active-low.
- sram_wen  out  1  SRAM write enable, active-low; tied to 1 (read-only).
- sram_addr  out  ADDR_WIDTH  SRAM address.
- sram_q  in  WORD_WIDTH  SRAM read data, valid one cycle after the request.
- base_valid  out  1  base_data is valid.
- base_ready  in  1  consumer accepts the base.
- base_data  out  BASE_BIT  current base.
- base_last  out  1  current base is the final one.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at the end of a request.

## Operation
- BPW = WORD_WIDTH/BASE_BIT = 64 bases per word. Base k of a word occupies bits [BASE_BIT*k+1 : BASE_BIT*k]; the LSB base is emitted first.
- Words to fetch = ceil(start_len/BPW). Only that many reads are issued. Address increments modulo 2^ADDR_WIDTH, so 2047 wraps to 0.
- FSM:
  - IDLE: start_ready=1. A start handshake latches addr and len. len==0 goes to DONE; otherwise STREAM.
  - STREAM: issues a read (sram_cen=0) whenever words remain AND (free slots − pending reads) > 0. The word is captured into the buffer on the edge ending the cycle after the request. Emits bases from the head slot. When the head's 64th base (or the final base) is accepted, the slot is freed and the head advances. Acceptance of the base_last base goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- base_last=1 when the remaining base count is 1. A partial final word emits only len mod BPW bases; its upper bits are discarded.
- Consumer stall (base_ready=0) holds base_data and base_valid stable. Prefetch continues until both slots are full or pending.
- Simultaneous capture of an incoming word and freeing of the head slot in one cycle is legal and must not lose data.
- start_valid outside IDLE is ignored.
- rst mid-operation: return to IDLE at the next edge. The buffer is invalidated and any in-flight SRAM data is dropped.
- Reset values: start_ready=1, sram_cen=1, sram_wen=1, sram_addr=0, base_valid=0, base_data=0, base_last=0, busy=0, done=0. All outputs are registered.

## Timing
- Start handshake in cycle 0.
- Cycle 1: first read, sram_addr=start_addr.
- Cycle 2: sram_q valid; second read issued if needed.
- Cycle 3: base_valid=1, base 0 presented.
- Start-to-first-base latency is 3 cycles.
- Sustained throughput is 1 base/cycle with no bubble at word boundaries while base_ready=1.
- done pulses the cycle after the last base handshake. start_ready returns the cycle after that.
- len==0: done in cycle 1 with no SRAM access.

## Structure
- Shared util header: Sram_Word_Bit and Sram_Addr_Bit (already present), plus a new Base_Bit define (2). FSM state encodings are local to the module.
- One sub-module, seq_word_buffer: a 2-entry word FIFO with a head shift register. Interface: push word, pop base, head-empty flag, occupancy.

## Test plan
- len=5 at addr 0x010, word 0x…1B (bases 3,2,1,0,…), ready=1 -> bases 3,2,1,0,0; last on the 5th; done 1 cycle later; exactly one read.
- len=128 at addr 0x020, ready=1 -> reads 0x020 and 0x021, 128 consecutive valid cycles with no bubble, first base at cycle 3.
- len=130 at addr 0x7FF -> reads 0x7FF, 0x000, 0x001; last base from bit [3:2] of the third word.
- len=70, base_ready toggling 1-0 every cycle -> 70 bases in order, data stable while stalled, no more than 2 words buffered or pending.
- len=0 -> done at cycle 1, sram_cen stays 1, base_valid never set.
- rst asserted at base 40 of a len=200 stream -> next cycle all outputs at reset values; a new start with len=3 streams correctly from its own address.
